btb_ras_predictor: RTL and testbench

Parametrised fetch-stage target predictor. It combines a direct-mapped, tagged branch target buffer (BTB) with valid bits and a per-entry jump type, plus a circular return address stack (RAS). It sits beside the IF-stage PC register. Lookup is combinational on the fetch PC. The ID stage trains the BTB. The RAS is pushed or popped speculatively when a fetch hits a call or return entry.

---
 rtl/btb_ras_predictor.sv | 130 +++++++++++++
 tb/tb_btb_ras_predictor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/btb_ras_predictor.sv
// Fetch target predictor: direct-mapped tagged BTB plus circular return stack.
// Latency: 0-cycle lookup, 1-edge train/RAS update; no backpressure, one RAS op per cycle.
module btb_ras_predictor #(
    parameter int PC_W      = 64,
    parameter int IDX_W     = 8,
    parameter int RAS_DEPTH = 16,
    parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [PC_W-1:0]      if_pc,
    output logic                 pred_hit,
    output logic [1:0]           pred_type,
    output logic [PC_W-1:0]      pred_target,
    input  logic                 upd_valid,
    input  logic [PC_W-1:0]      upd_pc,
    input  logic [PC_W-1:0]      upd_target,
    input  logic [1:0]           upd_type,
    input  logic                 btb_clear,
    output logic [RAS_PTR_W:0]   ras_count
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    localparam logic [1:0] TYPE_INV  = 2'b00;
    localparam logic [1:0] TYPE_CALL = 2'b10;
    localparam logic [1:0] TYPE_RET  = 2'b11;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [PC_W-1:0]    tgt_d [ENTRIES];
    logic [1:0]         typ_q [ENTRIES];
    logic [1:0]         typ_d [ENTRIES];

    logic [PC_W-1:0]    ras_q [RAS_DEPTH];
    logic [PC_W-1:0]    ras_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] tp_q, tp_d;
    logic [RAS_PTR_W:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   if_idx, upd_idx;
    logic [TAG_W-1:0]   if_tag, upd_tag;
    logic [PC_W-1:0]    if_pc_inc;
    logic [PC_W-1:0]    ras_top;
    logic               ras_push, ras_pop;
    logic               unused_ok;

    assign if_idx    = if_pc[IDX_W+1:2];
    assign if_tag    = if_pc[PC_W-1:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[PC_W-1:IDX_W+2];
    assign if_pc_inc = if_pc + PC_W'(4);
    assign ras_top   = ras_q[tp_q - RAS_PTR_W'(1)];
    assign ras_count = cnt_q;
    assign unused_ok = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup reads only registered state, so same-cycle training is read-before-write.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_type   = TYPE_INV;
        pred_target = if_pc_inc;
        if (pred_hit) begin
            pred_type   = typ_q[if_idx];
            pred_target = tgt_q[if_idx];
            if (typ_q[if_idx] == TYPE_RET && cnt_q != '0) begin
                pred_target = ras_top;
            end
        end
    end

    assign ras_push = if_valid && pred_hit && (pred_type == TYPE_CALL);
    assign ras_pop  = if_valid && pred_hit && (pred_type == TYPE_RET);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        typ_d   = typ_q;
        if (btb_clear) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_type != TYPE_INV) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_target;
                typ_d[upd_idx]   = upd_type;
            end else if (tag_q[upd_idx] == upd_tag) begin
                valid_d[upd_idx] = 1'b0;
            end
        end
    end

    // A push on a full stack reuses the oldest slot; the count saturates.
    always_comb begin
        ras_d = ras_q;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        if (ras_push) begin
            ras_d[tp_q] = if_pc_inc;
            tp_d        = tp_q + RAS_PTR_W'(1);
            if (cnt_q != (RAS_PTR_W+1)'(RAS_DEPTH)) begin
                cnt_d = cnt_q + (RAS_PTR_W+1)'(1);
            end
        end else if (ras_pop && cnt_q != '0) begin
            tp_d  = tp_q - RAS_PTR_W'(1);
            cnt_d = cnt_q - (RAS_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            tp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        typ_q <= typ_d;
        ras_q <= ras_d;
    end
endmodule

// File: tb/tb_btb_ras_predictor.sv
// Randomised and directed scoreboard bench for btb_ras_predictor.
// Expectations come from a queue/associative-array model of the BTB and return stack.
module tb_btb_ras_predictor;
    localparam int PC_W      = 64;
    localparam int IDX_W     = 8;
    localparam int RAS_DEPTH = 16;
    localparam int RAS_PTR_W = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                if_valid = 1'b0;
    logic [PC_W-1:0]     if_pc = '0;
    logic                pred_hit;
    logic [1:0]          pred_type;
    logic [PC_W-1:0]     pred_target;
    logic                upd_valid = 1'b0;
    logic [PC_W-1:0]     upd_pc = '0;
    logic [PC_W-1:0]     upd_target = '0;
    logic [1:0]          upd_type = 2'b00;
    logic                btb_clear = 1'b0;
    logic [RAS_PTR_W:0]  ras_count;

    btb_ras_predictor #(
        .PC_W(PC_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH), .RAS_PTR_W(RAS_PTR_W)
    ) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_type(pred_type), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_type(upd_type), .btb_clear(btb_clear), .ras_count(ras_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] tagv;
        logic [63:0] tgt;
        logic [1:0]  typ;
    } ent_t;

    typedef struct {
        logic        hit;
        logic [1:0]  typ;
        logic [63:0] tgt;
        int          cnt;
    } exp_t;

    ent_t        btb [int];
    logic [63:0] ras [$];
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) & ((64'd1 << IDX_W) - 1));
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: one expectation per checked cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pred_hit", 64'(pred_hit), 64'(e.hit));
            check("pred_type", 64'(pred_type), 64'(e.typ));
            check("pred_target", pred_target, e.tgt);
            check("ras_count", 64'(ras_count), 64'(e.cnt));
        end
    end

    task automatic step(input logic rst, input logic iv, input logic [63:0] ipc,
                        input logic uv, input logic [63:0] upc, input logic [63:0] utgt,
                        input logic [1:0] utyp, input logic clr, input bit chk);
        exp_t e;
        int   i;
        @(posedge clock);
        #1;
        reset = rst; if_valid = iv; if_pc = ipc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_type = utyp;
        btb_clear = clr;
        i     = idx_of(ipc);
        e.hit = btb.exists(i) && (btb[i].tagv == tag_of(ipc));
        e.typ = e.hit ? btb[i].typ : 2'b00;
        e.cnt = ras.size();
        if (!e.hit) e.tgt = ipc + 64'd4;
        else if (e.typ == 2'b11 && ras.size() > 0) e.tgt = ras[$];
        else e.tgt = btb[i].tgt;
        if (chk) exp_q.push_back(e);
        if (rst) begin
            btb.delete();
            ras.delete();
        end else begin
            if (clr) btb.delete();
            else if (uv) begin
                int ui;
                ui = idx_of(upc);
                if (utyp != 2'b00) btb[ui] = '{tagv: tag_of(upc), tgt: utgt, typ: utyp};
                else if (btb.exists(ui) && btb[ui].tagv == tag_of(upc)) btb.delete(ui);
            end
            if (iv && e.hit && e.typ == 2'b10) begin
                ras.push_back(ipc + 64'd4);
                if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
            end else if (iv && e.hit && e.typ == 2'b11 && ras.size() > 0) begin
                void'(ras.pop_back());
            end
        end
    endtask

    task automatic fetch(input logic [63:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic train(input logic [63:0] pc, input logic [63:0] tgt, input logic [1:0] typ);
        step(1'b0, 1'b0, 64'h8000_0000, 1'b1, pc, tgt, typ, 1'b0, 1'b1);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
        fetch(64'h8000_0000);

        train(64'h8000_0010, 64'h8000_0100, 2'b01);
        fetch(64'h8000_0010);
        fetch(64'h8000_0410);

        train(64'h8000_0020, 64'h8000_0200, 2'b10);
        train(64'h8000_0204, 64'hDEAD_0000, 2'b11);
        fetch(64'h8000_0020);
        fetch(64'h8000_0204);
        fetch(64'h8000_0204);
        fetch(64'h8000_0000);

        for (int k = 0; k < 17; k++) train(64'h8000_1040 + 64'(4 * k), 64'h8000_0204, 2'b10);
        for (int k = 0; k < 17; k++) fetch(64'h8000_1040 + 64'(4 * k));
        for (int k = 0; k < 18; k++) fetch(64'h8000_0204);

        train(64'h8000_0010, 64'h0, 2'b00);
        fetch(64'h8000_0010);
        train(64'h8000_0010, 64'h8000_0100, 2'b01);
        train(64'h8000_0410, 64'h0, 2'b00);
        fetch(64'h8000_0010);
        step(1'b0, 1'b0, 64'h8000_0000, 1'b1, 64'h8000_0030, 64'h1111, 2'b01, 1'b1, 1'b1);
        fetch(64'h8000_0010);
        fetch(64'h8000_0030);
        fetch(64'h8000_0020);

        step(1'b0, 1'b1, 64'h8000_0050, 1'b1, 64'h8000_0050, 64'h1234, 2'b01, 1'b0, 1'b1);
        fetch(64'h8000_0050);
        step(1'b0, 1'b1, 64'h8000_0050, 1'b1, 64'h8000_0050, 64'h5678, 2'b01, 1'b0, 1'b1);
        fetch(64'h8000_0050);
        fetch(64'hFFFF_FFFF_FFFF_FFFC);

        train(64'h8000_0020, 64'h8000_0200, 2'b10);
        fetch(64'h8000_0020);
        fetch(64'h8000_0020);
        step(1'b1, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0060, 64'h9, 2'b01, 1'b0, 1'b1);
        fetch(64'h8000_0020);
        fetch(64'h8000_0060);

        for (int n = 0; n < 3000; n++) begin
            logic [63:0] ipc, upc, utgt;
            logic [1:0]  utyp;
            logic        rst, clr, uv, iv;
            ipc  = 64'h8000_0000 | 64'($urandom_range(0, 31) << 2)
                 | 64'($urandom_range(0, 1) << 10) | 64'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) ipc = 64'hFFFF_FFFF_FFFF_FFFC;
            upc  = 64'h8000_0000 | 64'($urandom_range(0, 31) << 2)
                 | 64'($urandom_range(0, 1) << 10) | 64'($urandom_range(0, 3));
            utgt = {32'($urandom), 32'($urandom)};
            utyp = 2'($urandom_range(0, 3));
            uv   = ($urandom_range(0, 2) == 0);
            iv   = ($urandom_range(0, 5) != 0);
            clr  = ($urandom_range(0, 199) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            step(rst, iv, ipc, uv, upc, utgt, utyp, clr, 1'b1);
        end

        @(posedge clock);
        #1;
        if_valid = 1'b0; upd_valid = 1'b0; btb_clear = 1'b0;
        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
